// File: rtl/pipelined_permutation_network.sv
// Bufferless N-port (4/8) butterfly of oldest-first 2x2 cells with
// optional per-stage registers, deflection flags and a saturating counter.
module pipelined_permutation_network #(
   parameter int NUM_PORTS = 4,
   parameter int FLIT_W = 64,
   parameter int AGE_W = 8,
   parameter logic [$clog2(NUM_PORTS)-1:0] PIPE_MASK =
      {$clog2(NUM_PORTS){1'b1}},
   parameter bit AGE_ON_DEFLECT = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
   output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
   output logic [NUM_PORTS-1:0]        out_deflect,
   output logic [15:0]                 deflect_count,
   input  logic                        count_clr
);

   localparam int S = $clog2(NUM_PORTS);
   localparam int VLD = FLIT_W - 1;
   localparam int AGE_LO = FLIT_W - 1 - AGE_W;
   localparam int DST_LO = AGE_LO - S;
   localparam int VW = NUM_PORTS * FLIT_W;

   // 1 = the pair crosses over inside the cell
   function automatic logic cellSwap(
      input logic [FLIT_W-1:0] a,
      input logic [FLIT_W-1:0] c,
      input int                b
   );
      logic aWins;
      aWins = a[VLD] &&
              (!c[VLD] || a[AGE_LO +: AGE_W] >= c[AGE_LO +: AGE_W]);
      if (aWins)
         cellSwap = a[DST_LO + b];
      else if (c[VLD])
         cellSwap = !c[DST_LO + b];
      else
         cellSwap = 1'b0;
   endfunction

   logic [VW-1:0] links [S+1];

   assign links[0] = in_flit;

   for (genvar s = 0; s < S; s++) begin : gStage
      localparam int B = S - 1 - s;
      logic [VW-1:0] cellOut;

      always_comb begin
         int lo;
         int hi;
         cellOut = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            lo = i & ~(1 << B);
            hi = lo | (1 << B);
            if (cellSwap(links[s][lo*FLIT_W +: FLIT_W],
                         links[s][hi*FLIT_W +: FLIT_W], B))
               cellOut[i*FLIT_W +: FLIT_W] =
                  links[s][(i ^ (1 << B))*FLIT_W +: FLIT_W];
            else
               cellOut[i*FLIT_W +: FLIT_W] =
                  links[s][i*FLIT_W +: FLIT_W];
         end
      end

      if (PIPE_MASK[s]) begin : gReg
         logic [VW-1:0] pipeReg;

         always_ff @(posedge clk) begin
            if (reset)
               pipeReg <= '0;
            else
               pipeReg <= cellOut;
         end

         assign links[s+1] = pipeReg;
      end else begin : gWire
         assign links[s+1] = cellOut;
      end
   end

   always_comb begin
      logic [FLIT_W-1:0] f;
      logic              defl;
      out_flit = '0;
      out_deflect = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         f = links[S][p*FLIT_W +: FLIT_W];
         defl = f[VLD] && (f[DST_LO +: S] != p[S-1:0]);
         out_deflect[p] = defl;
         if (AGE_ON_DEFLECT && defl && f[AGE_LO +: AGE_W] != '1)
            f[AGE_LO +: AGE_W] = f[AGE_LO +: AGE_W] + 1'b1;
         if (f[VLD])
            out_flit[p*FLIT_W +: FLIT_W] = f;
      end
   end

   logic [16:0] countSum;

   always_comb begin
      countSum = {1'b0, deflect_count};
      for (int p = 0; p < NUM_PORTS; p++)
         countSum = countSum + 17'(out_deflect[p]);
   end

   always_ff @(posedge clk) begin
      if (reset || count_clr)
         deflect_count <= '0;
      else if (countSum[16])
         deflect_count <= '1;
      else
         deflect_count <= countSum[15:0];
   end

endmodule

// File: tb/tb_pipelined_permutation_network.sv
// Directed checks on a 4-port pipelined network plus a random
// stream against a behavioural model on an 8-port combinational one.
module tb_pipelined_permutation_network;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         count_clr;
   logic [255:0] in4;
   logic [255:0] out4;
   logic [3:0]   defl4;
   logic [15:0]  cnt4;
   logic [511:0] in8;
   logic [511:0] out8;
   logic [7:0]   defl8;
   logic [15:0]  cnt8;

   int nCompared = 0;
   int nMismatch = 0;

   pipelined_permutation_network #(
      .NUM_PORTS(4), .FLIT_W(64), .AGE_W(8),
      .PIPE_MASK(2'b11), .AGE_ON_DEFLECT(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .in_flit(in4),
      .out_flit(out4), .out_deflect(defl4),
      .deflect_count(cnt4), .count_clr(count_clr)
   );

   pipelined_permutation_network #(
      .NUM_PORTS(8), .FLIT_W(64), .AGE_W(8),
      .PIPE_MASK(3'b000), .AGE_ON_DEFLECT(1'b1)
   ) dut8 (
      .clk(clk), .reset(reset), .in_flit(in8),
      .out_flit(out8), .out_deflect(defl8),
      .deflect_count(cnt8), .count_clr(count_clr)
   );

   task automatic checkVal(
      input string        tag,
      input logic [511:0] got,
      input logic [511:0] exp
   );
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] f4(
      input logic v, input logic [7:0] age,
      input logic [1:0] dst, input logic [52:0] pay
   );
      return {v, age, dst, pay};
   endfunction

   function automatic logic [63:0] f8(
      input logic v, input logic [7:0] age,
      input logic [2:0] dst, input logic [51:0] pay
   );
      return {v, age, dst, pay};
   endfunction

   // oldest-first butterfly written over per-field arrays
   task automatic model8(
      input  logic [511:0] iv,
      output logic [511:0] ov,
      output logic [7:0]   od
   );
      logic        v  [8];
      logic [7:0]  ag [8];
      logic [2:0]  ds [8];
      logic [51:0] pl [8];
      logic        nv [8];
      logic [7:0]  na [8];
      logic [2:0]  nd [8];
      logic [51:0] np [8];
      int hi, w, l, wp, lp;
      for (int p = 0; p < 8; p++) begin
         v[p]  = iv[p*64 + 63];
         ag[p] = iv[p*64 + 55 +: 8];
         ds[p] = iv[p*64 + 52 +: 3];
         pl[p] = iv[p*64 +: 52];
      end
      for (int b = 2; b >= 0; b--) begin
         nv = v; na = ag; nd = ds; np = pl;
         for (int lo = 0; lo < 8; lo++) begin
            if (((lo >> b) & 1) == 0) begin
               hi = lo + (1 << b);
               if (v[lo] || v[hi]) begin
                  if (v[lo] && (!v[hi] || ag[lo] >= ag[hi])) begin
                     w = lo; l = hi;
                  end else begin
                     w = hi; l = lo;
                  end
                  wp = ds[w][b] ? hi : lo;
                  lp = (wp == lo) ? hi : lo;
                  nv[wp] = v[w]; na[wp] = ag[w];
                  nd[wp] = ds[w]; np[wp] = pl[w];
                  nv[lp] = v[l]; na[lp] = ag[l];
                  nd[lp] = ds[l]; np[lp] = pl[l];
               end
            end
         end
         v = nv; ag = na; ds = nd; pl = np;
      end
      ov = '0;
      od = '0;
      for (int p = 0; p < 8; p++) begin
         if (v[p]) begin
            od[p] = (int'(ds[p]) != p);
            if (od[p] && ag[p] != 8'hFF)
               ag[p] = ag[p] + 8'd1;
            ov[p*64 +: 64] = {1'b1, ag[p], ds[p], pl[p]};
         end
      end
   endtask

   logic [255:0] expV;
   logic [511:0] exp8;
   logic [511:0] mOut;
   logic [7:0]   mDefl;
   logic [63:0]  rf;
   int           nValid, nOutValid, nMatch;
   logic [7:0]   used;

   initial begin
      reset = 1'b1;
      count_clr = 1'b0;
      for (int p = 0; p < 4; p++)
         in4[p*64 +: 64] = f4(1'b1, 8'd7, 2'd0, 53'hB0 + 53'(p));
      in8 = '0;
      in8[63:0] = f8(1'b1, 8'd7, 3'd5, 52'h55);

      for (int k = 0; k < 3; k++) begin
         step();
         checkVal("rst_out", 512'(out4), 512'(0));
         checkVal("rst_defl", 512'(defl4), 512'(0));
         checkVal("rst_cnt", 512'(cnt4), 512'(0));
      end
      exp8 = '0;
      exp8[5*64 +: 64] = f8(1'b1, 8'd7, 3'd5, 52'h55);
      checkVal("comb_in_rst", out8, exp8);
      checkVal("comb_in_rst_defl", 512'(defl8), 512'(0));
      checkVal("rst_cnt8", 512'(cnt8), 512'(0));

      // release cycle carries the permutation vector
      reset = 1'b0;
      in4 = {f4(1'b1, 8'd1, 2'd0, 53'hA3), f4(1'b1, 8'd1, 2'd1, 53'hA2),
             f4(1'b1, 8'd1, 2'd2, 53'hA1), f4(1'b1, 8'd1, 2'd3, 53'hA0)};
      step();
      in4 = '0;
      checkVal("rel_lat1", 512'(out4), 512'(0));
      step();
      expV = {f4(1'b1, 8'd1, 2'd3, 53'hA0), f4(1'b1, 8'd1, 2'd2, 53'hA1),
              f4(1'b1, 8'd1, 2'd1, 53'hA2), f4(1'b1, 8'd1, 2'd0, 53'hA3)};
      checkVal("perm_out", 512'(out4), 512'(expV));
      checkVal("perm_defl", 512'(defl4), 512'(0));
      step();
      checkVal("perm_drain", 512'(out4), 512'(0));
      checkVal("perm_cnt", 512'(cnt4), 512'(0));

      in4 = {64'h0, f4(1'b1, 8'd9, 2'd2, 53'hC2),
             64'h0, f4(1'b1, 8'd5, 2'd2, 53'hC0)};
      step();
      in4 = '0;
      step();
      expV = {64'h0, f4(1'b1, 8'd9, 2'd2, 53'hC2),
              64'h0, f4(1'b1, 8'd6, 2'd2, 53'hC0)};
      checkVal("confl_out", 512'(out4), 512'(expV));
      checkVal("confl_defl", 512'(defl4), 512'(4'b0001));
      checkVal("confl_cnt0", 512'(cnt4), 512'(0));
      step();
      checkVal("confl_cnt1", 512'(cnt4), 512'(1));

      // every flit heads for port 0: three deflections per cycle
      for (int p = 0; p < 4; p++)
         in4[p*64 +: 64] = f4(1'b1, 8'd0, 2'd0, 53'hD0 + 53'(p));
      for (int k = 1; k <= 21900; k++) begin
         step();
         if (k == 10)
            checkVal("fill_cnt", 512'(cnt4), 512'(25));
      end
      checkVal("sat_cnt", 512'(cnt4), 512'(16'hFFFF));

      in4 = {64'h0, f4(1'b1, 8'd255, 2'd2, 53'hE2),
             64'h0, f4(1'b1, 8'd255, 2'd2, 53'hE0)};
      step();
      in4 = '0;
      step();
      expV = {64'h0, f4(1'b1, 8'd255, 2'd2, 53'hE0),
              64'h0, f4(1'b1, 8'd255, 2'd2, 53'hE2)};
      checkVal("tie_out", 512'(out4), 512'(expV));
      checkVal("tie_defl", 512'(defl4), 512'(4'b0001));
      step();
      checkVal("tie_sat_cnt", 512'(cnt4), 512'(16'hFFFF));

      in4 = {f4(1'b1, 8'd0, 2'd3, 53'hF3), f4(1'b1, 8'd1, 2'd3, 53'hF2),
             f4(1'b1, 8'd2, 2'd0, 53'hF1), f4(1'b1, 8'd3, 2'd0, 53'hF0)};
      step();
      step();
      expV = {f4(1'b1, 8'd1, 2'd3, 53'hF2), f4(1'b1, 8'd1, 2'd3, 53'hF3),
              f4(1'b1, 8'd3, 2'd0, 53'hF1), f4(1'b1, 8'd3, 2'd0, 53'hF0)};
      checkVal("clr_out", 512'(out4), 512'(expV));
      checkVal("clr_defl", 512'(defl4), 512'(4'b0110));
      checkVal("clr_pre", 512'(cnt4), 512'(16'hFFFF));
      count_clr = 1'b1;
      in4 = '0;
      step();
      count_clr = 1'b0;
      checkVal("clr_zero", 512'(cnt4), 512'(0));
      checkVal("clr_defl2", 512'(defl4), 512'(4'b0110));
      step();
      checkVal("clr_resume", 512'(cnt4), 512'(2));
      step();
      checkVal("clr_hold", 512'(cnt4), 512'(2));

      for (int k = 0; k < 10000; k++) begin
         step();
         for (int p = 0; p < 8; p++) begin
            rf = {$urandom, $urandom};
            rf[63] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
               0: rf[62:55] = 8'($urandom_range(0, 2));
               1: rf[62:55] = 8'($urandom_range(254, 255));
               default: ;
            endcase
            in8[p*64 +: 64] = rf;
         end
         #1;
         model8(in8, mOut, mDefl);
         checkVal("stream_out", out8, mOut);
         checkVal("stream_defl", 512'(defl8), 512'(mDefl));
         nValid = 0;
         nOutValid = 0;
         nMatch = 0;
         used = '0;
         for (int p = 0; p < 8; p++)
            if (out8[p*64 + 63] === 1'b1)
               nOutValid++;
         for (int p = 0; p < 8; p++) begin
            if (in8[p*64 + 63]) begin
               nValid++;
               for (int q = 0; q < 8; q++) begin
                  if (!used[q] && out8[q*64 + 63] === 1'b1 &&
                      out8[q*64 +: 55] === in8[p*64 +: 55]) begin
                     used[q] = 1'b1;
                     nMatch++;
                     break;
                  end
               end
            end
         end
         checkVal("conserve", 512'({nMatch, nOutValid}),
                  512'({nValid, nValid}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/pipelined_permutation_network.md
Name: pipelined_permutation_network

Overview:
Parametrised successor of the 4-port permutation network. It is a bufferless log2(N)-stage butterfly of 2x2 permuter cells for N = 4 or 8 ports, with optional pipeline registers after each stage. Arbitration is age-based (oldest-first) using a destination field carried in each flit. The block sits between the router's input latches and its output ports. Every valid input flit leaves on exactly one output port; losers are deflected. Misrouted flits are aged, flagged and counted.

Parameters:
NUM_PORTS, 4, number of ports; legal values 4 or 8. S = log2(NUM_PORTS).
FLIT_W, 64, flit width in bits, including header fields.
AGE_W, 8, width of the age field.
PIPE_MASK, {S{1'b1}}, S-bit mask; bit s=1 places a register after stage s.
AGE_ON_DEFLECT, 1, if 1, age is incremented (saturating) when a flit exits on a non-destination port.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
in_flit  input  NUM_PORTS*FLIT_W  packed input flits; port p occupies [p*FLIT_W +: FLIT_W].
out_flit  output  NUM_PORTS*FLIT_W  packed output flits; same packing as in_flit.
out_deflect  output  NUM_PORTS  per-port flag; 1 = a valid flit on that port is not at its destination.
deflect_count  output  16  saturating count of deflected flits.
count_clr  input  1  synchronous clear for deflect_count.

Behaviour:
- Flit format:
  - [FLIT_W-1]: valid.
  - next AGE_W bits: age.
  - next S bits: dst (destination port index).
  - remaining bits: payload. Payload passes through untouched.
- Stage s (s = 0..S-1):
  - Resolves dst bit b = S-1-s.
  - Pairs positions i and i^(1<<b), with i having bit b = 0.
  - The output positions of each cell are i (upper) and i^(1<<b) (lower).
- Cell arbitration:
  - Winner: the valid flit with the larger age. On an age tie, the flit at the lower position wins. An invalid flit always loses.
  - The winner goes to the position whose bit b equals winner.dst[b]. The loser takes the other position.
  - Two invalid flits: pass straight through.
  - Cells are purely combinational; age is not changed inside the network.
- Pipeline registers:
  - Present after stage s where PIPE_MASK[s]=1.
  - Register the full flit vector every cycle. There is no stall and no backpressure.
  - Throughput is one flit vector per cycle.
- Latency: popcount(PIPE_MASK) cycles. With PIPE_MASK=0 the block is fully combinational from in_flit to out_flit and out_deflect.
- Output stage (combinational, after the last stage or its register):
  - out_deflect[p] = valid && dst != p.
  - If AGE_ON_DEFLECT=1 and out_deflect[p]=1: age = min(age+1, 2^AGE_W-1).
  - Invalid output flits are driven all-zero.
- deflect_count:
  - Each cycle: deflect_count <= sat16(deflect_count + popcount(out_deflect)).
  - count_clr has priority: it forces 0 that cycle and discards that cycle's deflections.
- Reset:
  - Every pipeline register is cleared to 0 (valid=0), and deflect_count is set to 0.
  - While reset is high, registered outputs are 0 and deflect_count stays 0.
  - With PIPE_MASK=0, out_flit follows the combinational path even during reset.
  - Reset asserted mid-stream drops all in-flight flits. After release, the first output is the flit vector presented in the cycle reset deasserts, appearing popcount(PIPE_MASK) cycles later.
- Conservation: the multiset of valid flits in equals the multiset out (modulo age). No flit is duplicated or dropped.

Test Plan:
Reset: NUM_PORTS=4, PIPE_MASK=2'b11, valid flits driven while reset=1 for 3 cycles -> out_flit=0, out_deflect=0, deflect_count=0. The vector applied in the release cycle appears exactly 2 cycles later.
Conflict-free permutation: ports 0..3 carry dst 3,2,1,0, age 1 -> after 2 cycles port d holds the flit with dst d, age 1, payload intact, out_deflect=4'b0000.
Conflict: port0 {dst=2, age=5}, port2 {dst=2, age=9}, others invalid -> out port2 = age-9 flit; out port0 = dst-2 flit with age 6; out_deflect=4'b0001; deflect_count increments by 1.
Tie and saturation: port0 and port2 both {dst=2, age=255} -> port0 flit exits port2. Port2 flit exits port0 with age held at 255 (saturated). deflect_count preloaded to 16'hFFFF by repeated conflicts stays at 16'hFFFF.
count_clr priority: count_clr=1 in the same cycle as 2 deflections -> deflect_count=0 the next cycle; it resumes counting the cycle after.
Streaming with PIPE_MASK=0 and NUM_PORTS=8: random valid, dst and age every cycle for 10k cycles -> outputs are same-cycle combinational. A reference model matches every flit. Valid-flit conservation holds every cycle, and out_deflect matches dst != port.
